// File: rtl/simd_job_arbiter.sv
// ---------------------------------------------------------------------------
// simd_job_arbiter
//   Shares a single SIMD MAC accelerator between NUM_REQ requesters. Jobs
//   (data + weight vectors) are granted round-robin. The granted job is
//   latched onto the accelerator inputs and started with a one-cycle pulse.
//   The arbiter then waits for the result and hands it back to the winner
//   tagged with its id. If the accelerator never answers, the job is
//   abandoned after TIMEOUT+1 wait cycles and an error response is returned.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-requester job handshake (ready is one-hot, IDLE only)
//   req_data/weight   packed requester vectors, requester i at [i*VEC_W +: VEC_W]
//   acc_*             accelerator control, operand and result interface
//   rsp_valid/ready   response handshake toward the requesters
//   rsp_id            owner of the response
//   rsp_data/rsp_err  captured MAC vector, or 0 with rsp_err=1 on timeout
//   grant_id          id of the job in flight, or the last granted job
// ---------------------------------------------------------------------------
module simd_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int VEC_W   = 32,
  parameter int RES_W   = 64,
  parameter int TIMEOUT = 63,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_data,
  input  logic [NUM_REQ*VEC_W-1:0] req_weight,
  output logic                     acc_enable,
  output logic                     acc_start,
  output logic                     acc_data_valid,
  output logic [VEC_W-1:0]         acc_data,
  output logic [VEC_W-1:0]         acc_weight,
  input  logic                     acc_result_valid,
  input  logic [RES_W-1:0]         acc_mac_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [RES_W-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [ID_W-1:0]          grant_id
);

  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  ptr;
  logic [TMR_W-1:0] timer;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             accept;
  logic             timed_out;
  int               cand;

  // Round-robin search starting one past the last winner, wrapping around.
  // The first pending requester encountered wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  assign accept    = (state == ST_IDLE) && found;
  assign timed_out = (timer == TMR_W'(TIMEOUT));

  // Accept is only offered in IDLE, so a job can never be taken mid-flight.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A result that arrives on the final timeout cycle still
  // counts as a normal completion.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (acc_result_valid || timed_out) state_next = ST_RESP;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign acc_start      = (state == ST_ISSUE);
  assign acc_data_valid = (state == ST_ISSUE);
  assign rsp_valid      = (state == ST_RESP);
  assign rsp_id         = grant_id;

  // Datapath registers. The operand registers are only written on accept, so
  // the accelerator sees stable vectors for the whole job. The pointer resets
  // to the highest id so requester 0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_enable <= 1'b0;
      ptr        <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      acc_data   <= '0;
      acc_weight <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      timer      <= '0;
    end else begin
      acc_enable <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant_id   <= winner;
            ptr        <= winner;
            acc_data   <= req_data[int'(winner)*VEC_W +: VEC_W];
            acc_weight <= req_weight[int'(winner)*VEC_W +: VEC_W];
          end
        end
        ST_ISSUE: begin
          timer <= '0;
        end
        ST_WAIT: begin
          if (acc_result_valid) begin
            rsp_data <= acc_mac_out;
            rsp_err  <= 1'b0;
          end else if (timed_out) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simd_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_simd_job_arbiter
//   Directed bench for simd_job_arbiter. The bench plays the accelerator,
//   answering with a per-lane product vector after a chosen latency (or
//   never, to force a timeout), and compares every observed output against
//   values worked out from its own requester tables.
// ---------------------------------------------------------------------------
module tb_simd_job_arbiter;

  localparam int NUM_REQ = 4;
  localparam int VEC_W   = 32;
  localparam int RES_W   = 64;
  localparam int TIMEOUT = 63;
  localparam int ID_W    = 2;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*VEC_W-1:0] req_data;
  logic [NUM_REQ*VEC_W-1:0] req_weight;
  logic                     acc_enable;
  logic                     acc_start;
  logic                     acc_data_valid;
  logic [VEC_W-1:0]         acc_data;
  logic [VEC_W-1:0]         acc_weight;
  logic                     acc_result_valid;
  logic [RES_W-1:0]         acc_mac_out;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [RES_W-1:0]         rsp_data;
  logic                     rsp_err;
  logic [ID_W-1:0]          grant_id;

  logic [31:0] d [4];
  logic [31:0] w [4];
  logic [63:0] last_rsp;
  int          n_checks;
  int          n_fail;

  simd_job_arbiter #(
    .NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_weight(req_weight),
    .acc_enable(acc_enable), .acc_start(acc_start), .acc_data_valid(acc_data_valid),
    .acc_data(acc_data), .acc_weight(acc_weight),
    .acc_result_valid(acc_result_valid), .acc_mac_out(acc_mac_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .grant_id(grant_id)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference accelerator: four 8-bit unsigned lanes, each product in a 16-bit lane.
  function automatic logic [63:0] mac_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      r[l*16 +: 16] = 16'(a[l*8 +: 8]) * 16'(b[l*8 +: 8]);
    end
    return r;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete job: offer vmask, expect grant g, answer after lat WAIT
  // cycles (lat < 0 means never answer), hold rsp_ready low for stall cycles.
  task automatic apply_stimulus(input logic [3:0] vmask, input int g, input int lat, input int stall);
    logic [63:0] exp_data;
    logic        exp_err;
    logic [3:0]  one_hot;
    one_hot   = 4'b0001 << g;
    req_valid = vmask;
    #1;
    check_output("req_ready_grant", 64'(req_ready), 64'(one_hot));
    tick();
    check_output("issue_start", 64'(acc_start), 64'd1);
    check_output("issue_data_valid", 64'(acc_data_valid), 64'd1);
    check_output("issue_grant_id", 64'(grant_id), 64'(g));
    check_output("issue_acc_data", 64'(acc_data), 64'(d[g]));
    check_output("issue_acc_weight", 64'(acc_weight), 64'(w[g]));
    check_output("issue_no_ready", 64'(req_ready), 64'd0);
    tick();
    check_output("wait_start_low", 64'(acc_start), 64'd0);
    if (lat >= 0) begin
      repeat (lat) tick();
      exp_data         = mac_model(d[g], w[g]);
      exp_err          = 1'b0;
      acc_result_valid = 1'b1;
      acc_mac_out      = exp_data;
      tick();
      acc_result_valid = 1'b0;
      acc_mac_out      = JUNK;
    end else begin
      repeat (TIMEOUT) tick();
      check_output("timeout_not_early", 64'(rsp_valid), 64'd0);
      tick();
      exp_data = '0;
      exp_err  = 1'b1;
    end
    check_output("rsp_valid", 64'(rsp_valid), 64'd1);
    check_output("rsp_id", 64'(rsp_id), 64'(g));
    check_output("rsp_data", rsp_data, exp_data);
    check_output("rsp_err", 64'(rsp_err), 64'(exp_err));
    check_output("acc_data_held", 64'(acc_data), 64'(d[g]));
    for (int s = 0; s < stall; s++) begin
      tick();
      check_output("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check_output("stall_rsp_data", rsp_data, exp_data);
      check_output("stall_no_ready", 64'(req_ready), 64'd0);
    end
    last_rsp  = exp_data;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_output("rsp_done", 64'(rsp_valid), 64'd0);
    req_valid = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_rsp = '0;
    d[0] = 32'h0403_0201; w[0] = 32'h0202_0202;
    d[1] = 32'h1122_3344; w[1] = 32'h0102_0304;
    d[2] = 32'h0A0B_0C0D; w[2] = 32'h0303_0303;
    d[3] = 32'hFF80_017F; w[3] = 32'hFF02_FF01;
    req_data         = {d[3], d[2], d[1], d[0]};
    req_weight       = {w[3], w[2], w[1], w[0]};
    rst              = 1'b1;
    req_valid        = '0;
    acc_result_valid = 1'b0;
    acc_mac_out      = JUNK;
    rsp_ready        = 1'b0;

    $display("[TB] reset state");
    tick();
    tick();
    check_output("rst_acc_enable", 64'(acc_enable), 64'd0);
    check_output("rst_acc_start", 64'(acc_start), 64'd0);
    check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("rst_rsp_data", rsp_data, 64'd0);
    check_output("rst_grant_id", 64'(grant_id), 64'd0);
    check_output("rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    tick();
    check_output("acc_enable_on", 64'(acc_enable), 64'd1);

    $display("[TB] single job from requester 0");
    apply_stimulus(4'b0001, 0, 2, 0);
    check_output("single_job_vector", last_rsp, 64'h0008_0006_0004_0002);

    $display("[TB] result_valid in IDLE is ignored");
    acc_result_valid = 1'b1;
    acc_mac_out      = JUNK;
    tick();
    acc_result_valid = 1'b0;
    check_output("idle_result_no_rsp", 64'(rsp_valid), 64'd0);
    check_output("idle_result_no_capture", rsp_data, last_rsp);
    check_output("idle_result_no_start", 64'(acc_start), 64'd0);

    $display("[TB] response backpressure");
    apply_stimulus(4'b1111, 1, 3, 10);

    $display("[TB] wrap-around grant");
    apply_stimulus(4'b0100, 2, 0, 0);
    apply_stimulus(4'b0110, 1, 1, 0);

    $display("[TB] timeout and recovery");
    apply_stimulus(4'b0001, 0, -1, 0);
    apply_stimulus(4'b1000, 3, 4, 0);
    apply_stimulus(4'b0010, 1, TIMEOUT, 0);

    $display("[TB] reset during WAIT");
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    check_output("mid_wait_grant", 64'(grant_id), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    check_output("midrst_acc_enable", 64'(acc_enable), 64'd0);
    check_output("midrst_acc_start", 64'(acc_start), 64'd0);
    check_output("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("midrst_acc_data", 64'(acc_data), 64'd0);
    check_output("midrst_acc_weight", 64'(acc_weight), 64'd0);
    check_output("midrst_grant_id", 64'(grant_id), 64'd0);
    check_output("midrst_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    acc_result_valid = 1'b1;
    tick();
    acc_result_valid = 1'b0;
    tick();
    check_output("midrst_no_rsp", 64'(rsp_valid), 64'd0);

    $display("[TB] fairness with all requesters pending");
    for (int j = 0; j < 8; j++) begin
      apply_stimulus(4'b1111, j % NUM_REQ, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
